// File: rtl/lpf_sweep_ctrl.sv
// lpf_sweep_ctrl: frequency-response sweep scheduler for a DDS -> FIR low-pass chain.
// Steps the DDS frequency word through NSTEPS points. At each point it discards
// SETTLE_CYC valid FIR outputs, then records the peak |FIR output| over MEAS_CYC valid
// samples and offers it over a valid/ready handshake.
//
// Ports:
//   sclk, rst_n            clock, asynchronous active-low reset
//   start, abort           sweep start pulse (ignored while busy), synchronous abort
//   fword, fword_load      DDS frequency word and its 1-cycle load strobe
//   smp_valid              FIR input valid gate (high while settling/measuring)
//   fir_data, fir_valid    FIR output stream (signed)
//   res_data, res_idx      per-step peak magnitude (unsigned) and step index
//   res_valid, res_ready   result handshake
//   busy, done             sweep active, 1-cycle pulse after the last result is taken
//
// Build option: define SWEEP_LOOP_EN to restart the sweep from step 0 after every
// completed pass (runs until abort) instead of returning to idle.
module lpf_sweep_ctrl #(
  parameter int unsigned     FW_W       = 32,
  parameter int unsigned     DW         = 21,
  parameter logic [FW_W-1:0] FSTART     = FW_W'(4295),
  parameter logic [FW_W-1:0] FSTEP      = FW_W'(4295),
  parameter int unsigned     NSTEPS     = 16,
  parameter int unsigned     SETTLE_CYC = 64,
  parameter int unsigned     MEAS_CYC   = 256
) (
  input  logic            sclk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [FW_W-1:0] fword,
  output logic            fword_load,
  output logic            smp_valid,
  input  logic [DW-1:0]   fir_data,
  input  logic            fir_valid,
  output logic [DW-1:0]   res_data,
  output logic [7:0]      res_idx,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            busy,
  output logic            done
);

  localparam logic [31:0] SettleLast = 32'(SETTLE_CYC - 1);
  localparam logic [31:0] MeasLast   = 32'(MEAS_CYC - 1);
  localparam logic [7:0]  IdxLast    = 8'(NSTEPS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSettle,
    StMeasure,
    StReport,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        idx_q, idx_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [DW-1:0]     peak_q, peak_d;
  logic [FW_W-1:0]   fword_q, fword_d;
  logic [DW-1:0]     mag;

  // Negating the most negative value wraps to itself, which read as unsigned is 2^(DW-1).
  assign mag = fir_data[DW-1] ? (-fir_data) : fir_data;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    peak_d  = peak_q;
    fword_d = fword_q;
    if (state_q != StIdle && abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start && !abort) begin
            state_d = StLoad;
            idx_d   = 8'd0;
            fword_d = FSTART;
          end
        end
        StLoad: begin
          cnt_d   = 32'd0;
          peak_d  = '0;
          state_d = StSettle;
        end
        StSettle: begin
          if (fir_valid) begin
            if (cnt_q == SettleLast) begin
              cnt_d   = 32'd0;
              state_d = StMeasure;
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
        end
        StMeasure: begin
          if (fir_valid) begin
            if (mag > peak_q) peak_d = mag;
            if (cnt_q == MeasLast) begin
              state_d = StReport;
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
        end
        StReport: begin
          if (res_ready) begin
            if (idx_q == IdxLast) begin
              state_d = StDone;
            end else begin
              idx_d   = idx_q + 8'd1;
              fword_d = fword_q + FSTEP;
              state_d = StLoad;
            end
          end
        end
        StDone: begin
`ifdef SWEEP_LOOP_EN
          state_d = StLoad;
          idx_d   = 8'd0;
          fword_d = FSTART;
`else
          state_d = StIdle;
`endif
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= 8'd0;
      cnt_q      <= 32'd0;
      peak_q     <= '0;
      fword_q    <= '0;
      fword_load <= 1'b0;
      smp_valid  <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_idx    <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      peak_q     <= peak_d;
      fword_q    <= fword_d;
      fword_load <= (state_d == StLoad);
      smp_valid  <= (state_d == StSettle) || (state_d == StMeasure);
      res_valid  <= (state_d == StReport);
      res_data   <= (state_d == StReport) ? peak_d : '0;
      res_idx    <= (state_d == StReport) ? idx_d : 8'd0;
      busy       <= (state_d != StIdle);
      done       <= (state_d == StDone);
    end
  end

  assign fword = fword_q;

endmodule

// File: tb/tb_lpf_sweep_ctrl.sv
// Testbench for lpf_sweep_ctrl: random FIR sample streams checked against a per-step
// model (drop the first SETTLE valid samples, peak absolute value of the next MEAS).
module tb_lpf_sweep_ctrl;

  localparam int S   = 4;
  localparam int M   = 4;
  localparam int NST = 3;
  localparam logic [31:0] F0 = 32'd100;
  localparam logic [31:0] FS = 32'd50;

  logic        sclk = 1'b0;
  logic        rst_n, start, abort, fir_valid, res_ready;
  logic [20:0] fir_data;
  logic [31:0] fword;
  logic        fword_load, smp_valid, res_valid, busy, done;
  logic [20:0] res_data;
  logic [7:0]  res_idx;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [20:0] stim[$];
  int          gap_mode;
  int          hold_cyc;

  lpf_sweep_ctrl #(
    .FW_W(32), .DW(21), .FSTART(F0), .FSTEP(FS), .NSTEPS(NST), .SETTLE_CYC(S), .MEAS_CYC(M)
  ) dut (
    .sclk(sclk), .rst_n(rst_n), .start(start), .abort(abort),
    .fword(fword), .fword_load(fword_load), .smp_valid(smp_valid),
    .fir_data(fir_data), .fir_valid(fir_valid),
    .res_data(res_data), .res_idx(res_idx), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .done(done)
  );

  always #5 sclk = ~sclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic fill_stim(input int s, input int dmode);
    stim.delete();
    if (dmode == 1 && s == 0) begin
      for (int i = 0; i < S; i++) stim.push_back(21'd1000);
      stim.push_back(-21'sd5);
      stim.push_back(21'd7);
      stim.push_back(-21'sd300);
      stim.push_back(21'd2);
    end else if (dmode == 1 && s == 1) begin
      for (int i = 0; i < S; i++) stim.push_back(21'h1FFFFF);
      stim.push_back(21'h100000);
      for (int i = 1; i < M; i++) stim.push_back(21'd0);
    end else begin
      for (int i = 0; i < S + M; i++) begin
        if ($urandom_range(0, 9) == 0) stim.push_back(21'h100000);
        else stim.push_back(21'($urandom));
      end
    end
  endtask

  task automatic run_step(input int s, input bit last);
    int          waited, sent, cyc, v, expv;
    bit          bad, vld;
    logic [31:0] exp_fw;
    exp_fw = F0 + 32'(s) * FS;
    waited = 0;
    while (fword_load !== 1'b1 && waited < 8) begin
      @(negedge sclk);
      waited++;
    end
    n_checks++;
    if (fword_load !== 1'b1) begin
      n_fail++;
      $display("FAIL load_strobe step %0d: fword_load=%b want 1", s, fword_load);
    end
    n_checks++;
    if (fword !== exp_fw) begin
      n_fail++;
      $display("FAIL fword step %0d: got %0d want %0d", s, fword, exp_fw);
    end
    // A valid sample during LOAD must be ignored.
    fir_valid = 1'b1;
    fir_data  = 21'h0FFFFF;
    @(negedge sclk);
    n_checks++;
    if ({smp_valid, fword_load, busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL settle_entry step %0d: smp/load/busy=%b want 101", s,
               {smp_valid, fword_load, busy});
    end
    sent = 0;
    cyc  = 0;
    bad  = 1'b0;
    res_ready = (hold_cyc == 0);
    while (sent < S + M) begin
      case (gap_mode)
        0:       vld = 1'b1;
        1:       vld = ($urandom_range(0, 1) == 1);
        default: vld = ((cyc % 2) == 0);
      endcase
      start = ($urandom_range(0, 7) == 0);
      if (vld) begin
        fir_valid = 1'b1;
        fir_data  = stim[sent];
        sent++;
      end else begin
        fir_valid = 1'b0;
        fir_data  = 21'($urandom);
      end
      @(negedge sclk);
      cyc++;
      if (sent < S + M && (res_valid !== 1'b0 || smp_valid !== 1'b1 || fword_load !== 1'b0))
        bad = 1'b1;
    end
    fir_valid = 1'b0;
    start     = 1'b0;
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL early_result step %0d: result or gate wrong before %0d samples", s, S + M);
    end
    expv = 0;
    for (int i = S; i < S + M; i++) begin
      v = $signed(stim[i]);
      if (v < 0) v = -v;
      if (v > expv) expv = v;
    end
    n_checks++;
    if (res_valid !== 1'b1 || smp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL report_entry step %0d: res_valid=%b smp_valid=%b want 1 0", s,
               res_valid, smp_valid);
    end
    n_checks++;
    if (res_data !== 21'(expv)) begin
      n_fail++;
      $display("FAIL res_data step %0d: got %0d want %0d", s, res_data, expv);
    end
    n_checks++;
    if (res_idx !== 8'(s)) begin
      n_fail++;
      $display("FAIL res_idx step %0d: got %0d want %0d", s, res_idx, s);
    end
    bad = 1'b0;
    for (int k = 0; k < hold_cyc; k++) begin
      res_ready = 1'b0;
      @(negedge sclk);
      if (res_valid !== 1'b1 || res_data !== 21'(expv) || res_idx !== 8'(s) ||
          fword_load !== 1'b0 || done !== 1'b0)
        bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL report_hold step %0d: result not held stable while res_ready low", s);
    end
    res_ready = 1'b1;
    @(negedge sclk);
    res_ready = 1'b0;
    n_checks++;
    if (last) begin
      if (done !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL done_pulse: done=%b res_valid=%b busy=%b want 1 0 1", done, res_valid,
                 busy);
      end
    end else if (fword_load !== 1'b1 || done !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL next_load step %0d: load=%b done=%b res_valid=%b want 1 0 0", s,
               fword_load, done, res_valid);
    end
  endtask

  task automatic test_sweep(input int gm, input int hold, input int dmode);
    start = 1'b1;
    @(negedge sclk);
    start = 1'b0;
    for (int s = 0; s < NST; s++) begin
      fill_stim(s, dmode);
      gap_mode = gm;
      hold_cyc = hold;
      run_step(s, s == NST - 1);
    end
    @(negedge sclk);
    n_checks++;
`ifdef SWEEP_LOOP_EN
    if (fword_load !== 1'b1 || fword !== F0 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL loop_restart: load=%b fword=%0d busy=%b done=%b want 1 %0d 1 0",
               fword_load, fword, busy, done, F0);
    end
    abort = 1'b1;
    @(negedge sclk);
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL loop_abort: busy=%b done=%b want 0 0", busy, done);
    end
`else
    if (busy !== 1'b0 || done !== 1'b0 || fword_load !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_end: busy=%b done=%b load=%b want 0 0 0", busy, done, fword_load);
    end
`endif
  endtask

  task automatic test_reset;
    n_checks++;
    if ({fword, fword_load, smp_valid, res_data, res_idx, res_valid, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: fword=%0d load=%b smp=%b data=%0d idx=%0d rv=%b busy=%b done=%b",
               fword, fword_load, smp_valid, res_data, res_idx, res_valid, busy, done);
    end
  endtask

  task automatic test_reset_mid_measure;
    start = 1'b1;
    @(negedge sclk);
    start = 1'b0;
    fir_valid = 1'b1;
    for (int i = 0; i < 1 + S + 2; i++) begin
      fir_data = 21'(1000 + i);
      @(negedge sclk);
    end
    fir_valid = 1'b0;
    n_checks++;
    if (smp_valid !== 1'b1 || busy !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_measure: smp=%b busy=%b rv=%b want 1 1 0", smp_valid, busy, res_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge sclk);
    rst_n = 1'b1;
    @(negedge sclk);
    test_reset();
  endtask

  task automatic test_abort;
    bit bad;
    start = 1'b1;
    @(negedge sclk);
    start = 1'b0;
    fill_stim(0, 0);
    gap_mode = 1;
    hold_cyc = 0;
    run_step(0, 1'b0);
    fir_valid = 1'b1;
    fir_data  = 21'd9;
    @(negedge sclk);
    @(negedge sclk);
    abort = 1'b1;
    @(negedge sclk);
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || smp_valid !== 1'b0 || res_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%b smp=%b rv=%b done=%b want 0 0 0 0", busy, smp_valid,
               res_valid, done);
    end
    n_checks++;
    if (fword !== F0 + FS) begin
      n_fail++;
      $display("FAIL abort_fword: got %0d want %0d", fword, F0 + FS);
    end
    bad = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      fir_data = 21'($urandom);
      @(negedge sclk);
      if (busy | done | res_valid | fword_load | smp_valid) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL abort_quiet: activity seen after abort");
    end
    start = 1'b1;
    abort = 1'b1;
    @(negedge sclk);
    start = 1'b0;
    abort = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (busy | fword_load | done | smp_valid) bad = 1'b1;
      @(negedge sclk);
    end
    fir_valid = 1'b0;
    res_ready = 1'b0;
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL start_abort_idle: sweep began despite abort with start");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    fir_valid = 1'b0;
    fir_data = '0;
    res_ready = 1'b0;
    gap_mode = 0;
    hold_cyc = 0;
    repeat (3) @(negedge sclk);
    test_reset();
    rst_n = 1'b1;
    @(negedge sclk);
    test_reset();
    test_reset_mid_measure();
    test_sweep(0, 0, 0);   // back-to-back, ready high on entry
    test_sweep(0, 1, 1);   // directed magnitudes
    test_sweep(2, 10, 0);  // alternating valid, long stall
    test_sweep(1, 3, 0);   // random gaps
    test_abort();
    test_sweep(1, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
